// File: rtl/mandelbrot_pixel_sequencer.sv
// Walks a raster of H_RES x V_RES pixels, feeding each pixel's complex coordinate to an
// external escape-time iterator and emitting one RGB332 colour per pixel via a valid/ready write port.
module mandelbrot_pixel_sequencer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic signed [26:0] cr_init_i,
  input  logic signed [26:0] ci_init_i,
  input  logic signed [26:0] dx_i,
  input  logic signed [26:0] dy_i,
  input  logic [31:0]        max_iter_i,
  output logic signed [26:0] iter_cr_o,
  output logic signed [26:0] iter_ci_o,
  output logic               iter_reset_o,
  input  logic [31:0]        iter_num_i,
  input  logic               iter_done_i,
  output logic [9:0]         pix_x_o,
  output logic [8:0]         pix_y_o,
  output logic [7:0]         pix_color_o,
  output logic               pix_valid_o,
  input  logic               pix_ready_i,
  output logic               busy_o,
  output logic               frame_done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_WRITE   = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  state_t state_q, state_d;

  logic signed [26:0] cr0_q, cr0_d;
  logic signed [26:0] dx_q, dx_d;
  logic signed [26:0] dy_q, dy_d;
  logic [31:0]        max_iter_q, max_iter_d;
  logic signed [26:0] iter_cr_q, iter_cr_d;
  logic signed [26:0] iter_ci_q, iter_ci_d;
  logic [9:0]         pix_x_q, pix_x_d;
  logic [8:0]         pix_y_q, pix_y_d;
  logic [7:0]         color_q, color_d;

  logic x_last;
  logic y_last;

  assign x_last = (pix_x_q == X_LAST);
  assign y_last = (pix_y_q == Y_LAST);

  // Escape-count bands, checked from the slowest escape downwards.
  function automatic logic [7:0] rgb332(input logic [31:0] n, input logic [31:0] lim);
    logic [7:0] c;
    if (n >= lim)          c = 8'h00;
    else if (n >= 32'd64)  c = 8'hE0;
    else if (n >= 32'd16)  c = 8'hFC;
    else if (n >= 32'd4)   c = 8'h1C;
    else                   c = 8'h03;
    return c;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_LOAD;
      S_LOAD:    state_d = S_RUN;
      S_RUN:     if (iter_done_i) state_d = S_WRITE;
      S_WRITE:   if (pix_ready_i) state_d = S_ADVANCE;
      S_ADVANCE: state_d = (x_last && y_last) ? S_IDLE : S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iter_reset_o = (state_q == S_LOAD);
    pix_valid_o  = (state_q == S_WRITE);
    busy_o       = (state_q != S_IDLE);
    frame_done_o = (state_q == S_ADVANCE) && x_last && y_last;
  end

  always_comb begin
    cr0_d      = cr0_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    max_iter_d = max_iter_q;
    iter_cr_d  = iter_cr_q;
    iter_ci_d  = iter_ci_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    color_d    = color_q;
    case (state_q)
      S_IDLE: begin
        // Frame parameters are captured once so later input changes cannot disturb the frame.
        if (start_i) begin
          cr0_d      = cr_init_i;
          dx_d       = dx_i;
          dy_d       = dy_i;
          max_iter_d = max_iter_i;
          iter_cr_d  = cr_init_i;
          iter_ci_d  = ci_init_i;
          pix_x_d    = 10'd0;
          pix_y_d    = 9'd0;
        end
      end
      S_RUN: begin
        if (iter_done_i) color_d = rgb332(iter_num_i, max_iter_q);
      end
      S_ADVANCE: begin
        if (!x_last) begin
          pix_x_d   = pix_x_q + 10'd1;
          iter_cr_d = iter_cr_q + dx_q;
        end else if (!y_last) begin
          // Imaginary axis grows upwards, so each new row steps down by dy.
          pix_x_d   = 10'd0;
          pix_y_d   = pix_y_q + 9'd1;
          iter_cr_d = cr0_q;
          iter_ci_d = iter_ci_q - dy_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cr0_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      max_iter_q <= '0;
      iter_cr_q  <= '0;
      iter_ci_q  <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      color_q    <= '0;
    end else begin
      cr0_q      <= cr0_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      max_iter_q <= max_iter_d;
      iter_cr_q  <= iter_cr_d;
      iter_ci_q  <= iter_ci_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      color_q    <= color_d;
    end
  end

  assign iter_cr_o   = iter_cr_q;
  assign iter_ci_o   = iter_ci_q;
  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_color_o = color_q;

endmodule

// File: tb/tb_mandelbrot_pixel_sequencer.sv
// Directed bench for the pixel sequencer on a 4x3 raster with a behavioural iterator.
module tb_mandelbrot_pixel_sequencer;

  localparam int H = 4;
  localparam int V = 3;
  localparam int CR0_I = -16777216;
  localparam int CI0_I = 8388608;
  localparam int D_I   = 4194304;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic signed [26:0] cr_init = '0, ci_init = '0, dx = '0, dy = '0;
  logic [31:0] max_iter = '0;
  logic [26:0] iter_cr, iter_ci;
  logic        iter_reset;
  logic [31:0] iter_num;
  logic        iter_done;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_color;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  mandelbrot_pixel_sequencer #(.H_RES(H), .V_RES(V)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .cr_init_i(cr_init), .ci_init_i(ci_init), .dx_i(dx), .dy_i(dy),
    .max_iter_i(max_iter),
    .iter_cr_o(iter_cr), .iter_ci_o(iter_ci), .iter_reset_o(iter_reset),
    .iter_num_i(iter_num), .iter_done_i(iter_done),
    .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_color_o(pix_color),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  // Behavioural iterator: reports num_table[k] for the k-th restart, done_delay RUN cycles later.
  logic [31:0] num_table [12];
  int          done_delay = 2;
  logic        model_clear = 1'b0;
  logic        spurious_done = 1'b0;
  logic        num_ovr_en = 1'b0;
  logic [31:0] num_ovr = '0;
  logic        m_active = 1'b0;
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [31:0] m_num = '0;

  always @(posedge clk) begin
    if (model_clear) begin
      m_idx    <= 0;
      m_active <= 1'b0;
    end else if (iter_reset) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      m_num    <= num_table[m_idx % 12];
      m_idx    <= m_idx + 1;
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == done_delay - 1) m_active <= 1'b0;
    end
  end

  assign iter_done = (m_active && (m_cnt == done_delay - 1)) || spurious_done;
  assign iter_num  = num_ovr_en ? num_ovr : m_num;

  // Monitor: records every pixel transfer, frame_done pulse and iter_reset timestamp.
  int cyc = 0;
  int wr_n = 0, fd_n = 0, fd_wr_at = 0, rs_n = 0, rs_last = 0, rs_prev = 0;
  logic [9:0]  wr_x  [128];
  logic [8:0]  wr_y  [128];
  logic [7:0]  wr_c  [128];
  logic [26:0] wr_cr [128];
  logic [26:0] wr_ci [128];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      if (wr_n < 128) begin
        wr_x[wr_n]  <= pix_x;
        wr_y[wr_n]  <= pix_y;
        wr_c[wr_n]  <= pix_color;
        wr_cr[wr_n] <= iter_cr;
        wr_ci[wr_n] <= iter_ci;
      end
      wr_n <= wr_n + 1;
      $display("write %0d: x=%0d y=%0d color=%02h cr=%07h ci=%07h", wr_n, pix_x, pix_y, pix_color, iter_cr, iter_ci);
    end
    if (frame_done) begin
      fd_n     <= fd_n + 1;
      fd_wr_at <= wr_n;
    end
    if (iter_reset) begin
      rs_prev <= rs_last;
      rs_last <= cyc;
      rs_n    <= rs_n + 1;
    end
  end

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] exp_color(input logic [31:0] n, input logic [31:0] lim);
    if (n >= lim) return 8'h00;
    if (n >= 64)  return 8'hE0;
    if (n >= 16)  return 8'hFC;
    if (n >= 4)   return 8'h1C;
    return 8'h03;
  endfunction

  task automatic start_frame();
    cr_init  = 27'(CR0_I);
    ci_init  = 27'(CI0_I);
    dx       = 27'(D_I);
    dy       = 27'(D_I);
    max_iter = 32'd1000;
    model_clear = 1'b1;
    step(1);
    model_clear = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int fd_base, input string tag);
    int t = 0;
    while (fd_n == fd_base && t < 600) begin
      step(1);
      t++;
    end
    check_eq(tag, 64'(fd_n != fd_base), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!pix_valid && t < 100) begin
      step(1);
      t++;
    end
    check_eq(tag, 64'(pix_valid), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},       64'(busy), 64'd0);
    check_eq({tag, "_pix_valid"},  64'(pix_valid), 64'd0);
    check_eq({tag, "_iter_reset"}, 64'(iter_reset), 64'd0);
    check_eq({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check_eq({tag, "_pix_x"},      64'(pix_x), 64'd0);
    check_eq({tag, "_pix_y"},      64'(pix_y), 64'd0);
    check_eq({tag, "_pix_color"},  64'(pix_color), 64'd0);
    check_eq({tag, "_iter_cr"},    64'(iter_cr), 64'd0);
    check_eq({tag, "_iter_ci"},    64'(iter_ci), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, fb, rb, t;
    logic [26:0] e27;
    logic [31:0] tbl1 [12];

    tbl1 = '{32'd1000, 32'd999, 32'd64, 32'd63, 32'd16, 32'd15,
             32'd4, 32'd3, 32'd0, 32'd2000, 32'd5, 32'd17};

    #3;
    check_idle_outputs("reset");
    step(2);
    reset = 1'b0;
    step(2);

    // Frame 1: raster order, coordinates, colour bands; inputs scrambled after acceptance.
    for (int i = 0; i < 12; i++) num_table[i] = tbl1[i];
    done_delay = 2;
    pix_ready  = 1'b1;
    wb = wr_n;
    fb = fd_n;
    start_frame();
    check_eq("f1_busy", 64'(busy), 64'd1);
    cr_init  = 27'h0123456;
    ci_init  = 27'h0654321;
    dx       = 27'h0000001;
    dy       = 27'h7000000;
    max_iter = 32'd5;
    wait_frame(fb, "f1_frame_done_timeout");
    step(3);
    check_eq("f1_writes", 64'(wr_n - wb), 64'd12);
    check_eq("f1_fd_count", 64'(fd_n - fb), 64'd1);
    check_eq("f1_fd_after_write", 64'(fd_wr_at - wb), 64'd12);
    check_eq("f1_busy_end", 64'(busy), 64'd0);
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("f1_x[%0d]", k), 64'(wr_x[wb + k]), 64'(k % H));
      check_eq($sformatf("f1_y[%0d]", k), 64'(wr_y[wb + k]), 64'(k / H));
      check_eq($sformatf("f1_color[%0d]", k), 64'(wr_c[wb + k]), 64'(exp_color(tbl1[k], 32'd1000)));
      e27 = 27'(CR0_I + (k % H) * D_I);
      check_eq($sformatf("f1_cr[%0d]", k), 64'(wr_cr[wb + k]), 64'(e27));
      e27 = 27'(CI0_I - (k / H) * D_I);
      check_eq($sformatf("f1_ci[%0d]", k), 64'(wr_ci[wb + k]), 64'(e27));
    end
    e27 = 27'h7C00000;
    check_eq("f1_pixel32_cr", 64'(wr_cr[wb + 11]), 64'(e27));
    check_eq("f1_pixel32_ci", 64'(wr_ci[wb + 11]), 64'd0);

    // Frame 2: backpressure on the first pixel.
    for (int i = 0; i < 12; i++) num_table[i] = 32'd20;
    done_delay = 3;
    pix_ready  = 1'b0;
    wb = wr_n;
    fb = fd_n;
    start_frame();
    wait_valid("f2_valid_timeout");
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("bp_valid[%0d]", c), 64'(pix_valid), 64'd1);
      check_eq($sformatf("bp_x[%0d]", c), 64'(pix_x), 64'd0);
      check_eq($sformatf("bp_y[%0d]", c), 64'(pix_y), 64'd0);
      check_eq($sformatf("bp_color[%0d]", c), 64'(pix_color), 64'hFC);
      check_eq($sformatf("bp_writes[%0d]", c), 64'(wr_n - wb), 64'd0);
      step(1);
    end
    pix_ready = 1'b1;
    step(1);
    check_eq("bp_single_transfer", 64'(wr_n - wb), 64'd1);
    check_eq("bp_valid_drop", 64'(pix_valid), 64'd0);
    wait_frame(fb, "f2_frame_done_timeout");
    step(3);
    check_eq("f2_writes", 64'(wr_n - wb), 64'd12);

    // Frame 3: 7-cycle iterator gives a 10-cycle pixel period.
    done_delay = 7;
    fb = fd_n;
    rb = rs_n;
    start_frame();
    t = 0;
    while (rs_n - rb < 3 && t < 100) begin
      step(1);
      t++;
    end
    check_eq("lat_pulses_seen", 64'(rs_n - rb >= 3), 64'd1);
    check_eq("lat_mid_period", 64'(rs_last - rs_prev), 64'd10);
    wait_frame(fb, "f3_frame_done_timeout");
    check_eq("lat_last_period", 64'(rs_last - rs_prev), 64'd10);
    check_eq("f3_iter_resets", 64'(rs_n - rb), 64'd12);
    step(3);

    // Frame 4: asynchronous reset in RUN of pixel (2,1).
    fb = fd_n;
    start_frame();
    t = 0;
    while (!(pix_x == 10'd2 && pix_y == 9'd1 && iter_reset) && t < 200) begin
      step(1);
      t++;
    end
    check_eq("rst_reach_pixel21", 64'(iter_reset), 64'd1);
    step(2);
    check_eq("rst_in_run_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    step(2);
    reset = 1'b0;
    wb = wr_n;
    rb = rs_n;
    spurious_done = 1'b1;
    step(2);
    spurious_done = 1'b0;
    step(1);
    check_eq("midrst_no_fd", 64'(fd_n - fb), 64'd0);
    check_eq("spur_idle_busy", 64'(busy), 64'd0);
    check_eq("spur_idle_writes", 64'(wr_n - wb), 64'd0);
    check_eq("spur_idle_resets", 64'(rs_n - rb), 64'd0);

    // Frame 5: restart from (0,0) after the abandoned frame.
    done_delay = 1;
    fb = fd_n;
    wb = wr_n;
    start_frame();
    check_eq("restart_iter_reset", 64'(iter_reset), 64'd1);
    check_eq("restart_x", 64'(pix_x), 64'd0);
    check_eq("restart_y", 64'(pix_y), 64'd0);
    e27 = 27'(CR0_I);
    check_eq("restart_cr", 64'(iter_cr), 64'(e27));
    e27 = 27'(CI0_I);
    check_eq("restart_ci", 64'(iter_ci), 64'(e27));
    wait_frame(fb, "f5_frame_done_timeout");
    step(3);
    check_eq("f5_writes", 64'(wr_n - wb), 64'd12);

    // Frame 6: start while busy and iter_done during WRITE are both ignored.
    for (int i = 0; i < 12; i++) num_table[i] = 32'd1000;
    done_delay = 2;
    pix_ready  = 1'b0;
    fb = fd_n;
    wb = wr_n;
    start_frame();
    wait_valid("f6_valid_timeout");
    start = 1'b1;
    spurious_done = 1'b1;
    num_ovr_en = 1'b1;
    num_ovr = 32'd0;
    step(1);
    start = 1'b0;
    spurious_done = 1'b0;
    num_ovr_en = 1'b0;
    check_eq("spur_write_color", 64'(pix_color), 64'h00);
    check_eq("spur_write_valid", 64'(pix_valid), 64'd1);
    check_eq("spur_write_x", 64'(pix_x), 64'd0);
    pix_ready = 1'b1;
    step(6);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_frame(fb, "f6_frame_done_timeout");
    rb = rs_n;
    step(10);
    check_eq("f6_writes", 64'(wr_n - wb), 64'd12);
    check_eq("f6_fd_count", 64'(fd_n - fb), 64'd1);
    check_eq("f6_no_second_frame", 64'(busy), 64'd0);
    check_eq("f6_no_new_load", 64'(rs_n - rb), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
